gpio_writer: RTL and testbench

GPIO_WRITER -- requirements
Module: gpio_writer

---
 rtl/gpio_writer.sv | 101 ++++++++++
 tb/tb_gpio_writer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_writer.sv
// Bit-banged GPIO command decoder: one action per w_clk high period, feeding an
// instruction assembler, a B-value AXIS source, two config registers and a start strobe.
module gpio_writer #(
    parameter logic [6:0] ADDR_INSTR   = 7'h10,
    parameter logic [6:0] ADDR_B       = 7'h11,
    parameter logic [6:0] ADDR_MAC_DEL = 7'h12,
    parameter logic [6:0] ADDR_NL_DEL  = 7'h13,
    parameter logic [6:0] ADDR_START   = 7'h14,
    parameter logic [6:0] ADDR_CLR     = 7'h15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] gpio_in,
    output logic        ack,
    output logic [63:0] instr_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] b_data,
    output logic        b_valid,
    input  logic        b_ready,
    output logic [15:0] del_meas_mac_cfg,
    output logic [15:0] del_meas_nl_cfg,
    output logic        start_pulse,
    output logic [1:0]  word_cnt
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t      state;
    logic        w_clk;
    logic [6:0]  addr;
    logic [15:0] wr_data;
    logic        unused_bits;

    assign w_clk       = gpio_in[31];
    assign addr        = gpio_in[30:24];
    assign wr_data     = gpio_in[15:0];
    assign unused_bits = ^gpio_in[23:16];

    // Reset parks the FSM in HOLD so a w_clk already high at release is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= HOLD;
            ack              <= 1'b0;
            instr_valid      <= 1'b0;
            b_valid          <= 1'b0;
            start_pulse      <= 1'b0;
            word_cnt         <= 2'd0;
            instr_data       <= 64'd0;
            b_data           <= 16'd0;
            del_meas_mac_cfg <= 16'd0;
            del_meas_nl_cfg  <= 16'd0;
        end else begin
            start_pulse <= 1'b0;
            if (instr_valid && instr_ready) instr_valid <= 1'b0;
            if (b_valid && b_ready)         b_valid     <= 1'b0;

            case (state)
                IDLE: begin
                    if (w_clk) begin
                        state <= HOLD;
                        ack   <= 1'b1;
                        // Pre-edge valid flags gate the pushes, so a write landing on the
                        // handshake cycle is still rejected.
                        if (addr == ADDR_INSTR) begin
                            if (!instr_valid) begin
                                instr_data[{word_cnt, 4'd0} +: 16] <= wr_data;
                                word_cnt <= word_cnt + 2'd1;
                                if (word_cnt == 2'd3) instr_valid <= 1'b1;
                            end else begin
                                ack <= 1'b0;
                            end
                        end else if (addr == ADDR_B) begin
                            if (!b_valid) begin
                                b_data  <= wr_data;
                                b_valid <= 1'b1;
                            end else begin
                                ack <= 1'b0;
                            end
                        end else if (addr == ADDR_MAC_DEL) begin
                            del_meas_mac_cfg <= wr_data;
                        end else if (addr == ADDR_NL_DEL) begin
                            del_meas_nl_cfg <= wr_data;
                        end else if (addr == ADDR_START) begin
                            start_pulse <= 1'b1;
                        end else if (addr == ADDR_CLR) begin
                            word_cnt <= 2'd0;
                        end
                    end
                end
                HOLD: begin
                    if (!w_clk) begin
                        state <= IDLE;
                        ack   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_writer.sv
// Randomized + directed bench for gpio_writer: a spec-level model fills scoreboard
// queues, and an independent monitor compares DUT outputs against them.
module tb_gpio_writer;

    localparam logic [6:0] A_INSTR = 7'h10;
    localparam logic [6:0] A_B     = 7'h11;
    localparam logic [6:0] A_MAC   = 7'h12;
    localparam logic [6:0] A_NL    = 7'h13;
    localparam logic [6:0] A_START = 7'h14;
    localparam logic [6:0] A_CLR   = 7'h15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_in = 32'd0;
    logic        ack;
    logic [63:0] instr_data;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] b_data;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic [15:0] del_meas_mac_cfg;
    logic [15:0] del_meas_nl_cfg;
    logic        start_pulse;
    logic [1:0]  word_cnt;

    gpio_writer #(
        .ADDR_INSTR(A_INSTR), .ADDR_B(A_B), .ADDR_MAC_DEL(A_MAC),
        .ADDR_NL_DEL(A_NL), .ADDR_START(A_START), .ADDR_CLR(A_CLR)
    ) dut (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .ack(ack),
        .instr_data(instr_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .del_meas_mac_cfg(del_meas_mac_cfg), .del_meas_nl_cfg(del_meas_nl_cfg),
        .start_pulse(start_pulse), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] parts[$];
    logic [63:0] instr_q[$];
    logic [15:0] b_q[$];
    logic        ack_q[$];
    logic        armed    = 1'b0;
    logic        pend_i   = 1'b0;
    logic        pend_b   = 1'b0;
    logic        exp_ack  = 1'b0;
    logic        exp_start = 1'b0;
    logic [63:0] img      = 64'd0;
    logic [15:0] exp_b    = 16'd0;
    logic [15:0] exp_mac  = 16'd0;
    logic [15:0] exp_nl   = 16'd0;
    logic        irdy     = 1'b0;
    logic        brdy     = 1'b0;
    logic        rand_rdy = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        parts.delete(); instr_q.delete(); b_q.delete(); ack_q.delete();
        armed = 1'b0; pend_i = 1'b0; pend_b = 1'b0;
        exp_ack = 1'b0; exp_start = 1'b0;
        img = 64'd0; exp_b = 16'd0; exp_mac = 16'd0; exp_nl = 16'd0;
    endtask

    // Effect of one rising edge given the inputs presented before it.
    task automatic model_edge(input logic wc, input logic [6:0] a, input logic [15:0] d,
                              input logic ir, input logic br);
        logic fire_i, fire_b, acc;
        int   idx;
        fire_i    = pend_i && ir;
        fire_b    = pend_b && br;
        exp_start = 1'b0;
        if (!armed) begin
            if (!wc) begin
                armed   = 1'b1;
                exp_ack = 1'b0;
            end
        end else if (wc) begin
            armed = 1'b0;
            acc   = 1'b1;
            if (a == A_INSTR) begin
                if (pend_i) acc = 1'b0;
                else begin
                    idx = parts.size();
                    img[idx*16 +: 16] = d;
                    parts.push_back(d);
                    if (parts.size() == 4) begin
                        instr_q.push_back({parts[3], parts[2], parts[1], parts[0]});
                        parts.delete();
                        pend_i = 1'b1;
                    end
                end
            end else if (a == A_B) begin
                if (pend_b) acc = 1'b0;
                else begin
                    exp_b = d;
                    b_q.push_back(d);
                    pend_b = 1'b1;
                end
            end else if (a == A_MAC)   exp_mac = d;
            else if (a == A_NL)        exp_nl = d;
            else if (a == A_START)     exp_start = 1'b1;
            else if (a == A_CLR)       parts.delete();
            exp_ack = acc;
            ack_q.push_back(acc);
        end
        if (fire_i) pend_i = 1'b0;
        if (fire_b) pend_b = 1'b0;
    endtask

    task automatic tick(input logic wc, input logic [6:0] a, input logic [15:0] d);
        if (rand_rdy) begin
            irdy = ($urandom % 3) == 0;
            brdy = ($urandom % 3) == 0;
        end
        gpio_in     = {wc, a, 8'($urandom), d};
        instr_ready = irdy;
        b_ready     = brdy;
        @(posedge clk);
        #1;
        if (rst) model_edge(wc, a, d, irdy, brdy);
    endtask

    task automatic wr(input logic [6:0] a, input logic [15:0] d, input int hi, input int lo);
        for (int i = 0; i < hi; i++) tick(1'b1, a, d);
        for (int i = 0; i < lo; i++) tick(1'b0, a, d);
    endtask

    // Monitor: stream handshakes consume scoreboard entries
    always @(posedge clk) begin
        if (rst && instr_valid && instr_ready) begin
            if (instr_q.size() == 0) chk("instr_unexpected", {63'd0, instr_valid}, 64'd0);
            else void'(instr_q.pop_front());
        end
        if (rst && b_valid && b_ready) begin
            if (b_q.size() == 0) chk("b_unexpected", {63'd0, b_valid}, 64'd0);
            else void'(b_q.pop_front());
        end
    end

    // Monitor: output state compared on the falling edge
    always @(negedge clk) begin
        logic e;
        if (ack_q.size() != 0) begin
            e = ack_q.pop_front();
            chk("write_ack", {63'd0, ack}, {63'd0, e});
        end
        chk("ack", {63'd0, ack}, {63'd0, exp_ack});
        chk("start_pulse", {63'd0, start_pulse}, {63'd0, exp_start});
        chk("word_cnt", {62'd0, word_cnt}, 64'(parts.size()));
        chk("instr_valid", {63'd0, instr_valid}, {63'd0, instr_q.size() != 0});
        chk("instr_data", instr_data, img);
        if (instr_valid && instr_q.size() != 0) chk("instr_stream", instr_data, instr_q[0]);
        chk("b_valid", {63'd0, b_valid}, {63'd0, b_q.size() != 0});
        chk("b_data", {48'd0, b_data}, {48'd0, exp_b});
        if (b_valid && b_q.size() != 0) chk("b_stream", {48'd0, b_data}, {48'd0, b_q[0]});
        chk("mac_cfg", {48'd0, del_meas_mac_cfg}, {48'd0, exp_mac});
        chk("nl_cfg", {48'd0, del_meas_nl_cfg}, {48'd0, exp_nl});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts;
        logic [6:0] ra;
        rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 7'h0, 16'h0);
        rst = 1'b1;
        tick(1'b0, 7'h0, 16'h0);

        // Four slices assemble one instruction; fifth is rejected while pending
        wr(A_INSTR, 16'h1111, 1, 1);
        wr(A_INSTR, 16'h2222, 2, 1);
        wr(A_INSTR, 16'h3333, 1, 2);
        wr(A_INSTR, 16'h4444, 1, 1);
        chk("r033_data", instr_data, 64'h4444_3333_2222_1111);
        chk("r033_valid", {63'd0, instr_valid}, 64'd1);
        chk("r033_cnt", {62'd0, word_cnt}, 64'd0);
        wr(A_INSTR, 16'h5555, 1, 1);
        chk("r034_keep", instr_data, 64'h4444_3333_2222_1111);
        irdy = 1'b1;
        tick(1'b0, 7'h0, 16'h0);
        irdy = 1'b0;
        chk("r034_drain", {63'd0, instr_valid}, 64'd0);
        wr(A_INSTR, 16'h6666, 1, 1);
        chk("r034_slice0", {48'd0, instr_data[15:0]}, 64'h6666);

        // Write landing on the handshake cycle is rejected
        wr(A_INSTR, 16'h7777, 1, 1);
        wr(A_INSTR, 16'h8888, 1, 1);
        wr(A_INSTR, 16'h9999, 1, 1);
        irdy = 1'b1;
        tick(1'b1, A_INSTR, 16'hAAAA);
        irdy = 1'b0;
        tick(1'b1, A_INSTR, 16'hAAAA);
        tick(1'b0, A_INSTR, 16'hAAAA);
        chk("same_cycle_cnt", {62'd0, word_cnt}, 64'd0);

        // Long w_clk on START gives a single strobe
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, A_START, 16'h0);
            starts += int'(start_pulse);
        end
        chk("r035_ack_held", {63'd0, ack}, 64'd1);
        tick(1'b0, A_START, 16'h0);
        chk("r035_starts", 64'(starts), 64'd1);

        // CLR discards a partial instruction
        wr(A_INSTR, 16'hDEAD, 1, 1);
        wr(A_INSTR, 16'hBEEF, 1, 1);
        wr(A_CLR, 16'h0, 1, 1);
        wr(A_INSTR, 16'hA001, 1, 1);
        wr(A_INSTR, 16'hA002, 1, 1);
        wr(A_INSTR, 16'hA003, 1, 1);
        wr(A_INSTR, 16'hA004, 1, 1);
        chk("r036_data", instr_data, 64'hA004_A003_A002_A001);
        irdy = 1'b1;
        tick(1'b0, 7'h0, 16'h0);
        irdy = 1'b0;

        // B push, rejection while pending, drain
        wr(A_B, 16'hBEEF, 1, 1);
        wr(A_B, 16'h0001, 1, 1);
        chk("r037_bdata", {48'd0, b_data}, 64'hBEEF);
        brdy = 1'b1;
        tick(1'b0, 7'h0, 16'h0);
        brdy = 1'b0;
        chk("r037_bvalid", {63'd0, b_valid}, 64'd0);
        wr(A_MAC, 16'h1234, 1, 1);
        wr(A_NL, 16'h5678, 1, 1);
        wr(7'h7F, 16'hFFFF, 1, 1);

        // Reset mid-assembly with w_clk held high across release
        wr(A_INSTR, 16'h0101, 1, 1);
        wr(A_INSTR, 16'h0202, 1, 0);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) tick(1'b1, A_INSTR, 16'h0303);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, A_INSTR, 16'h0303);
        chk("r038_noaction", {62'd0, word_cnt}, 64'd0);
        tick(1'b0, A_INSTR, 16'h0);
        wr(A_INSTR, 16'hAAAA, 1, 1);
        chk("r038_cnt", {62'd0, word_cnt}, 64'd1);
        chk("r038_slice", {48'd0, instr_data[15:0]}, 64'hAAAA);

        // Randomized traffic with random back-pressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 500; n++) begin
            case ($urandom % 8)
                0, 1, 2: ra = A_INSTR;
                3:       ra = A_B;
                4:       ra = 7'($urandom_range(32'h12, 32'h15));
                5:       ra = A_CLR;
                6:       ra = A_START;
                default: ra = 7'($urandom);
            endcase
            wr(ra, 16'($urandom), $urandom_range(1, 3), $urandom_range(1, 2));
        end
        rand_rdy = 1'b0;
        irdy = 1'b1;
        brdy = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 7'h0, 16'h0);
        chk("drain_instr", 64'(instr_q.size()), 64'd0);
        chk("drain_b", 64'(b_q.size()), 64'd0);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
